// File: rtl/frame_dispatcher.sv
// frame_dispatcher
//   Routes each decoded inbound frame to one of NUM_TGT bus-side consumers
//   using a small EID match table, runs the req/ack handshake with the chosen
//   target, keeps fragmented frames on the same target, and discards frames
//   that are empty, unroutable or not accepted within TIMEOUT cycles.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_frame_valid        frame present in inbound buffer
//   header_done/eid       decoded header (level) and its EID
//   packet_is_empty       length byte was 0x00
//   is_fragment           length byte was 0xFF, more fragments follow
//   header_done_clear     one-cycle pulse, frame consumed
//   tgt_req/ack/sel       one-hot request, target accept, routed index
//   frame_discard         one-cycle pulse, upstream drops the frame
//   cfg_we/idx/eid/en     match-table write port
//   locked, busy          fragment lock active, not idle
//   drop_count            saturating discard counter
module frame_dispatcher #(
  parameter int NUM_TGT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_frame_valid,
  input  logic               header_done,
  input  logic [7:0]         header_eid,
  input  logic               packet_is_empty,
  input  logic               is_fragment,
  output logic               header_done_clear,
  output logic [NUM_TGT-1:0] tgt_req,
  input  logic [NUM_TGT-1:0] tgt_ack,
  output logic [1:0]         tgt_sel,
  output logic               frame_discard,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_idx,
  input  logic [7:0]         cfg_eid,
  input  logic               cfg_en,
  output logic               locked,
  output logic               busy,
  output logic [7:0]         drop_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REQ, S_ACTIVE, S_DISCARD, S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [NUM_TGT-1:0]      tbl_en;
  logic [NUM_TGT-1:0][7:0] tbl_eid;
  logic [1:0]              sel;
  logic [1:0]              lock_tgt;
  logic                    lock_q;
  logic [15:0]             timer;
  logic                    clr_q;
  logic [7:0]              drops;

  logic       hit;
  logic [1:0] hit_idx;
  logic       ack_hit;
  logic       tmo;

  // Priority match: scan from the top so the lowest matching index is the
  // last one written and therefore wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (tbl_en[i] && tbl_eid[i] == header_eid) begin
        hit     = 1'b1;
        hit_idx = i[1:0];
      end
    end
  end

  assign ack_hit = tgt_ack[sel];
  assign tmo     = (timer == 16'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (header_done) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (packet_is_empty)  state_nx = S_DISCARD;
        else if (lock_q)      state_nx = S_REQ;
        else if (hit)         state_nx = S_REQ;
        else                  state_nx = S_DISCARD;
      end
      S_REQ: begin
        // Ack has priority over a timeout landing on the same edge.
        if (ack_hit)          state_nx = S_ACTIVE;
        else if (tmo)         state_nx = S_DISCARD;
      end
      // Stay in ACTIVE while the clear pulse is still out: upstream may keep
      // header_done high for one more cycle, and IDLE must not see it.
      S_ACTIVE:  if (!in_frame_valid && !clr_q) state_nx = S_IDLE;
      S_DISCARD: state_nx = S_DRAIN;
      S_DRAIN:   if (!in_frame_valid) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sel      <= 2'd0;
      lock_q   <= 1'b0;
      lock_tgt <= 2'd0;
      timer    <= 16'd0;
      clr_q    <= 1'b0;
      drops    <= 8'd0;
      for (int i = 0; i < NUM_TGT; i++) begin
        tbl_en[i]  <= 1'b1;
        tbl_eid[i] <= 8'(i);
      end
    end else begin
      state <= state_nx;
      clr_q <= (state == S_REQ) && ack_hit;

      if (cfg_we) begin
        tbl_en[cfg_idx]  <= cfg_en;
        tbl_eid[cfg_idx] <= cfg_eid;
      end

      if (state == S_LOOKUP) begin
        if (packet_is_empty) lock_q <= 1'b0;
        else if (lock_q)     sel    <= lock_tgt;
        else if (hit)        sel    <= hit_idx;
      end

      if (state == S_REQ) begin
        timer <= timer + 16'd1;
        if (ack_hit) begin
          lock_q   <= is_fragment;
          lock_tgt <= sel;
        end else if (tmo) begin
          lock_q <= 1'b0;
        end
      end else if (state_nx == S_REQ) begin
        timer <= 16'd0;
      end

      if (state == S_DISCARD && drops != 8'hFF) drops <= drops + 8'd1;
    end
  end

  assign tgt_req           = (state == S_REQ) ? (NUM_TGT'(1) << sel) : '0;
  assign tgt_sel           = sel;
  assign frame_discard     = (state == S_DISCARD);
  assign header_done_clear = clr_q || (state == S_DISCARD);
  assign locked            = lock_q;
  assign busy              = (state != S_IDLE);
  assign drop_count        = drops;

endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed bench for frame_dispatcher. A frame-level model (routing table,
// lock, drop counter, expected output timeline) drives exp_* values; one
// process compares every output against them each cycle on the falling edge.
module tb_frame_dispatcher;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_frame_valid, header_done, packet_is_empty, is_fragment;
  logic [7:0] header_eid;
  logic       header_done_clear, frame_discard, locked, busy;
  logic [3:0] tgt_req, tgt_ack;
  logic [1:0] tgt_sel;
  logic       cfg_we, cfg_en;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_eid;
  logic [7:0] drop_count;

  frame_dispatcher #(.NUM_TGT(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_frame_valid(in_frame_valid),
    .header_done(header_done), .header_eid(header_eid),
    .packet_is_empty(packet_is_empty), .is_fragment(is_fragment),
    .header_done_clear(header_done_clear), .tgt_req(tgt_req),
    .tgt_ack(tgt_ack), .tgt_sel(tgt_sel), .frame_discard(frame_discard),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_eid(cfg_eid), .cfg_en(cfg_en),
    .locked(locked), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // model state
  bit         m_en [4];
  logic [7:0] m_eid [4];
  bit         m_locked;
  logic [1:0] m_lock_tgt;
  int         m_drops;
  logic [3:0] exp_req;
  logic [1:0] exp_sel;
  bit         exp_hdc, exp_disc, exp_busy;
  bit         chk_en = 0;

  int    checks = 0, errors = 0;
  bit    lit_req = 0;
  string lit_nm;
  int    lit_act, lit_exp;

  task automatic cmp(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("tgt_req", int'(tgt_req), int'(exp_req));
      cmp("tgt_sel", int'(tgt_sel), int'(exp_sel));
      cmp("hdr_clear", int'(header_done_clear), int'(exp_hdc));
      cmp("discard", int'(frame_discard), int'(exp_disc));
      cmp("busy", int'(busy), int'(exp_busy));
      cmp("locked", int'(locked), int'(m_locked));
      cmp("drop_count", int'(drop_count), m_drops);
    end
    if (lit_req) cmp(lit_nm, lit_act, lit_exp);
  end

  task automatic lit(input string nm, input int act, input int expv);
    lit_nm = nm; lit_act = act; lit_exp = expv; lit_req = 1;
    @(negedge clk); #1;
    lit_req = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_en[i] = 1; m_eid[i] = 8'(i); end
    m_locked = 0; m_lock_tgt = 0; m_drops = 0;
    exp_req = 0; exp_sel = 0; exp_hdc = 0; exp_disc = 0; exp_busy = 0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [7:0] eid, input bit en);
    cfg_we = 1; cfg_idx = idx; cfg_eid = eid; cfg_en = en;
    step();
    cfg_we = 0;
    m_en[idx] = en; m_eid[idx] = eid;
  endtask

  // Lowest-index enabled entry whose EID matches.
  task automatic route(input logic [7:0] eid, output bit hit, output logic [1:0] s);
    hit = 0; s = 0;
    for (int i = 0; i < 4; i++)
      if (!hit && m_en[i] && m_eid[i] == eid) begin hit = 1; s = 2'(i); end
  endtask

  // One frame: header_done raised, ack on REQ cycle ack_at (0 = never),
  // in_frame_valid dropped 'drain' cycles after the clear pulse, optional
  // reset on REQ cycle rst_at. req_cnt = cycles the DUT showed a request.
  task automatic frame(input logic [7:0] eid, input bit empty, input bit frag,
                       input int ack_at, input int drain, input logic [3:0] stray,
                       input int rst_at, output int req_cnt);
    bit hit, acked;
    logic [1:0] s;
    req_cnt = 0; acked = 0;
    header_eid = eid; packet_is_empty = empty; is_fragment = frag;
    header_done = 1; in_frame_valid = 1;
    step();
    exp_busy = 1;
    route(eid, hit, s);
    if (empty) hit = 0;
    else if (m_locked) begin hit = 1; s = m_lock_tgt; end
    step();
    if (empty) m_locked = 0;
    if (hit) begin
      exp_sel = s; exp_req = 4'b0001 << s;
      for (int c = 1; c <= TMO; c++) begin
        if (tgt_req != 0) req_cnt++;
        if (c == rst_at) begin
          rst = 1; step();
          rst = 0; header_done = 0; in_frame_valid = 0; tgt_ack = 0;
          model_reset();
          step();
          return;
        end
        tgt_ack = stray & ~(4'b0001 << s);
        if (c == ack_at) tgt_ack[s] = 1'b1;
        step();
        tgt_ack = 0;
        if (c == ack_at) begin acked = 1; break; end
      end
      exp_req = 0;
      if (acked) begin exp_hdc = 1; m_locked = frag; m_lock_tgt = s; end
    end
    if (!acked) begin
      exp_disc = 1; exp_hdc = 1;
      if (hit) m_locked = 0;
    end
    step();
    exp_disc = 0; exp_hdc = 0;
    if (!acked && m_drops < 255) m_drops++;
    // header_done lingers through this cycle; busy falls at the first edge
    // that sees in_frame_valid low.
    for (int d = 0; d < 1000; d++) begin
      if (d >= drain) in_frame_valid = 0;
      step();
      header_done = 0;
      if (!in_frame_valid) break;
    end
    exp_busy = 0;
    step();
  endtask

  int n;

  initial begin
    rst = 1; in_frame_valid = 0; header_done = 0; header_eid = 0;
    packet_is_empty = 0; is_fragment = 0; tgt_ack = 0;
    cfg_we = 0; cfg_idx = 0; cfg_eid = 0; cfg_en = 0;
    model_reset();
    step();
    chk_en = 1;
    step();
    rst = 0;
    step();
    lit("rst_busy", int'(busy), 0);
    lit("rst_req", int'(tgt_req), 0);
    lit("rst_drops", int'(drop_count), 0);

    // default table, EID 2, ack after 3 cycles, stray ack on target 1
    frame(8'h02, 0, 0, 3, 2, 4'b0010, 0, n);
    lit("t1_req_cycles", n, 3);
    lit("t1_sel", int'(tgt_sel), 2);

    // entry 1 remapped to EID 2: lowest index wins
    cfg(2'd1, 8'h02, 1);
    frame(8'h02, 0, 0, 1, 0, 4'b0000, 0, n);
    lit("prio_sel", int'(tgt_sel), 1);

    // all entries disabled: unroutable frame is discarded
    for (int i = 0; i < 4; i++) cfg(2'(i), m_eid[i], 0);
    frame(8'h07, 0, 0, 1, 1, 4'b0000, 0, n);
    lit("nomatch_req", n, 0);
    lit("nomatch_drops", int'(drop_count), 1);

    // fragment lock
    cfg(2'd3, 8'h03, 1);
    frame(8'h03, 0, 1, 2, 1, 4'b0001, 0, n);
    lit("frag_locked", int'(locked), 1);
    frame(8'h00, 0, 1, 1, 0, 4'b0000, 0, n);
    lit("locked_sel", int'(tgt_sel), 3);
    frame(8'h05, 0, 0, 1, 0, 4'b0000, 0, n);
    lit("unlock", int'(locked), 0);

    // empty packet while locked
    frame(8'h03, 0, 1, 1, 0, 4'b0000, 0, n);
    frame(8'h03, 1, 0, 1, 0, 4'b0000, 0, n);
    lit("empty_req", n, 0);
    lit("empty_locked", int'(locked), 0);
    lit("empty_drops", int'(drop_count), 2);

    // timeout, then ack on the timeout cycle
    frame(8'h03, 0, 0, 0, 1, 4'b1111, 0, n);
    lit("tmo_req_cycles", n, 4);
    lit("tmo_drops", int'(drop_count), 3);
    frame(8'h03, 0, 0, 4, 0, 4'b0000, 0, n);
    lit("ack_tmo_cycles", n, 4);
    lit("ack_tmo_drops", int'(drop_count), 3);

    // saturation
    for (int i = 0; i < 256; i++) frame(8'h07, 0, 0, 0, 0, 4'b0000, 0, n);
    lit("sat_drops", int'(drop_count), 255);

    // reset during REQ, then table back at defaults
    frame(8'h03, 0, 0, 0, 0, 4'b0000, 2, n);
    lit("rst_mid_busy", int'(busy), 0);
    lit("rst_mid_drops", int'(drop_count), 0);
    frame(8'h01, 0, 0, 2, 0, 4'b0000, 0, n);
    lit("post_rst_sel", int'(tgt_sel), 1);

    step();
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_dispatcher.md
# frame_dispatcher

Routes each decoded inbound frame to one of four bus-side consumers based on the header EID, and sequences frame release. Sits directly after the header decoder. Consumes `header_done`, `header_eid`, `packet_is_empty` and `is_fragment`, and drives `header_done_clear`. Handles EID-to-target lookup, the request/acknowledge handshake with the selected target, fragment stickiness, timeout and discard of unroutable frames.

## Interface
- `NUM_TGT`, 4: number of targets; fixed at 4 in this revision.
- `TIMEOUT`, 255: cycles to wait for `tgt_ack` before discarding; range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_frame_valid`  in  1  frame present in the inbound buffer.
- `header_done`  in  1  header decoded, level.
- `header_eid`  in  8  decoded EID.
- `packet_is_empty`  in  1  packet length byte was 0x00.
- `is_fragment`  in  1  length byte was 0xFF; more fragments follow.
- `header_done_clear`  out  1  one-cycle pulse; frame has been consumed by the dispatcher.
- `tgt_req`  out  4  one-hot request to the selected target.
- `tgt_ack`  in  4  target accepts the frame; single-cycle or level.
- `tgt_sel`  out  2  index of the routed target; held through ACTIVE.
- `frame_discard`  out  1  one-cycle pulse; upstream drops the current frame.
- `cfg_we`  in  1  write the match entry.
- `cfg_idx`  in  2  entry index.
- `cfg_eid`  in  8  match EID.
- `cfg_en`  in  1  entry enable.
- `locked`  out  1  fragment lock active.
- `busy`  out  1  state ≠ IDLE.
- `drop_count`  out  8  saturating count of discarded frames.

## Operation
- **Match table.** Four entries of {en, eid}. Reset values: entry i = {1, 8'h0i}.
  - `cfg_we` writes entry `cfg_idx` on the same edge.
  - A write may occur in any state. LOOKUP uses the table value at the LOOKUP edge.
- **Match rule.** Lowest-index enabled entry with `eid == header_eid` wins. No match means discard.
- **States.**
  - IDLE: if `header_done` → LOOKUP.
  - LOOKUP, one cycle, register route:
    - if `packet_is_empty` → DISCARD, and clear the lock;
    - else if `locked` → REQ with `sel` = the locked target, ignoring EID;
    - else if a match is found → REQ with `sel` = match;
    - else → DISCARD.
  - REQ: `tgt_req[sel]` = 1 and the timer increments.
    - `tgt_ack[sel]` → ACTIVE. Pulse `header_done_clear`. Set `locked` = `is_fragment`, recording `sel` as the lock target.
    - Timer reaches TIMEOUT-1 without ack → DISCARD. Clear the lock.
    - Acks on non-selected bits are ignored.
  - ACTIVE: `tgt_req` = 0; the target drains the frame. When `in_frame_valid` = 0 → IDLE.
  - DISCARD, one cycle:
    - `frame_discard` = 1 and `header_done_clear` = 1;
    - `drop_count` += 1, saturating at 255;
    - → DRAIN.
  - DRAIN: when `in_frame_valid` = 0 → IDLE.
- **Timer.** 16 bits; zeroed on entry to REQ.
- **Reset mid-operation.** Returns to IDLE. `tgt_req` drops the same edge.
- **Simultaneous `tgt_ack` and timeout in the same cycle.** Ack wins.

## Timing
- **Reset values:**
  - state IDLE;
  - `tgt_req` = 0, `tgt_sel` = 0;
  - `header_done_clear` = 0, `frame_discard` = 0;
  - `locked` = 0, `drop_count` = 0, `busy` = 0.
- **Outputs.** All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- **Request latency.**
  - `header_done` sampled high at edge N → LOOKUP at N+1.
  - `tgt_req` high from N+2.
- **Ack.** `tgt_ack` sampled at edge M → `header_done_clear` high for cycle M+1 → ACTIVE from M+1.
- **Discard path.** `header_done` at edge N → `frame_discard` and `header_done_clear` high in cycle N+2 only.
- **Timeout.** `tgt_req` is held for exactly TIMEOUT cycles when no ack arrives.
- **No re-dispatch.**
  - IDLE re-arms only after `in_frame_valid` falls.
  - The same frame is never dispatched twice, even if `header_done` lingers one cycle.

## Test plan
- Default table, EID 0x02, length 0x05, target 2 acks after 3 cycles → `tgt_req` = 4'b0100 for 3 cycles, one `header_done_clear`, `tgt_sel` = 2, IDLE after `in_frame_valid` falls.
- `cfg_we` idx1 eid 0x02, then EID 0x02 arrives → target 1 selected by lowest-index priority. `cfg_en` = 0 on all entries with EID 0x07 → `frame_discard` pulse, `drop_count` = 1.
- Fragment: EID 0x03 with `is_fragment` = 1 acked → `locked` = 1. Next frame EID 0x00 routes to target 3. Next non-fragment frame clears `locked`.
- Empty packet (`packet_is_empty` = 1) while locked → discard, `locked` = 0, `tgt_req` never asserted.
- TIMEOUT = 4, no ack → `tgt_req` held 4 cycles, then `frame_discard`. Ack and timeout in the same cycle → ACTIVE, no discard. 256 discards → `drop_count` stays 255.
- `rst` asserted during REQ → `tgt_req` = 0 next cycle, all outputs at reset values.
